ic_sram_port: RTL

- Target-side adapter downstream of the interconnect. It terminates one req/gnt/recv/ack memory port, such as the RAM or ROM instruction or data port, onto a synchronous single-port SRAM/ROM macro with 1-cycle read latency.
- Buffers responses so it can accept one request per cycle while the CPU stalls the ack.
- Optionally read-only, for use in front of the ROM.

---
 rtl/ic_sram_port.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ic_sram_port.sv
// Memory-port target adapter: req/gnt/recv/ack onto a 1-cycle-latency SRAM/ROM.
// Responses go through a small FIFO so a stalled ack never loses read data.
module ic_sram_port #(
    parameter int ADDR_W    = 14,
    parameter int RSP_DEPTH = 2,
    parameter bit READ_ONLY = 1'b0
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [3:0]        mem_strb,
    input  logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_addr,
    output logic              mem_gnt,
    output logic              mem_recv,
    input  logic              mem_ack,
    output logic              mem_error,
    output logic [31:0]       mem_rdata,
    output logic              sram_cs,
    output logic              sram_wen,
    output logic [3:0]        sram_strb,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] CMAX = CW'(RSP_DEPTH);
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(RSP_DEPTH);

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pend;
    logic          pend_wen;
    logic          pend_err;
    logic          hold_q;
    logic [32:0]   fifo [RSP_DEPTH];

    logic          acc;
    logic          ro_wr;
    logic          push;
    logic          pop;
    logic [CW:0]   occ;
    logic [31:0]   pend_rdata;
    logic [32:0]   head;
    logic          unused_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

    // Occupancy counts the pending slot so a full FIFO is never over-granted.
    assign occ     = {1'b0, count} + {{CW{1'b0}}, pend};
    assign mem_gnt = g_resetn && (occ < DEPTH_V);
    assign acc     = mem_req && mem_gnt;
    assign ro_wr   = READ_ONLY && mem_wen;

    assign sram_cs    = acc && !ro_wr;
    assign sram_wen   = mem_wen;
    assign sram_strb  = mem_strb;
    assign sram_wdata = mem_wdata;
    assign sram_addr  = mem_addr[ADDR_W-1:2];

    assign pend_rdata = pend_wen ? 32'h0 : sram_rdata;
    assign head       = fifo[rd_ptr];

    assign pop  = (count != '0) && mem_ack;
    assign push = pend && !((count == '0) && mem_ack);

    always_comb begin
        mem_recv  = 1'b0;
        mem_rdata = 32'h0;
        mem_error = 1'b0;
        if (g_resetn) begin
            if (count != '0) begin
                mem_recv  = 1'b1;
                mem_rdata = head[31:0];
                mem_error = head[32];
            end else if (pend) begin
                mem_recv  = 1'b1;
                mem_rdata = pend_rdata;
                mem_error = pend_err;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            pend     <= 1'b0;
            pend_wen <= 1'b0;
            pend_err <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            hold_q   <= 1'b0;
        end else begin
            assert (count <= CMAX);
            assert (!(push && count == CMAX));
            if (hold_q) begin
                assert (mem_recv);
            end
            pend     <= acc;
            pend_wen <= mem_wen;
            pend_err <= ro_wr;
            hold_q   <= mem_recv && !mem_ack;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge g_clk) begin
        if (g_resetn && push) begin
            fifo[wr_ptr] <= {pend_err, pend_rdata};
        end
    end

endmodule
